// File: rtl/adder_pkg.sv
// Shared constants for the skewed pipelined adder.
// Holds default operand/chunk widths and the stage-count derivation.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // One pipeline stage per CHUNK-bit slice of the operands.
    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    localparam int DEF_STAGES = num_stages(DEF_WIDTH, DEF_CHUNK);

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple-carry slice used by each pipeline stage.
// Ports: a, b, cin in; s, cout (carry out of MSB), c_msb (carry into MSB) out.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Skewed pipelined adder/subtractor, CHUNK bits resolved per stage.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, cin, sub;
// out_valid/out_ready, sum, cout (no-borrow when subtracting), ovf.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;

    // One skewed pipeline slot. b is stored already inverted for subtract,
    // so later stages need no knowledge of the operation. s accumulates the
    // chunks produced so far; c is the carry handed to the next chunk.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cmsb;
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    stage_t src     [STAGES];

    logic [CHUNK-1:0] ck_a  [STAGES];
    logic [CHUNK-1:0] ck_b  [STAGES];
    logic             ck_ci [STAGES];
    logic [CHUNK-1:0] ck_s  [STAGES];
    logic             ck_co [STAGES];
    logic             ck_cm [STAGES];

    logic advance;

    // A full output slot that is not being taken freezes the whole pipe.
    assign out_valid = stage_q[LAST].valid;
    assign in_ready  = !(out_valid && !out_ready);
    assign advance   = in_ready;

    // Stage inputs: stage 0 reads the ports, every other stage reads the
    // register of the previous stage.
    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid;
        src[0].a     = a;
        src[0].b     = sub ? ~b : b;
        src[0].c     = sub ? 1'b1 : cin;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stage_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            ck_a[k]  = src[k].a[k*CHUNK +: CHUNK];
            ck_b[k]  = src[k].b[k*CHUNK +: CHUNK];
            ck_ci[k] = src[k].c;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_chunk #(
            .W (CHUNK)
        ) u_chunk (
            .a     (ck_a[k]),
            .b     (ck_b[k]),
            .cin   (ck_ci[k]),
            .s     (ck_s[k]),
            .cout  (ck_co[k]),
            .c_msb (ck_cm[k])
        );
    end

    // Only the last stage's carry-into-MSB is meaningful: bit WIDTH-1 is
    // the top bit of the final chunk.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_q[k];
            if (advance) begin
                stage_d[k]                     = src[k];
                stage_d[k].s[k*CHUNK +: CHUNK] = ck_s[k];
                stage_d[k].c                   = ck_co[k];
                stage_d[k].cmsb                = ck_cm[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign sum  = stage_q[LAST].s;
    assign cout = stage_q[LAST].c;
    assign ovf  = stage_q[LAST].c ^ stage_q[LAST].cmsb;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, CHUNK=4).
// Directed vectors, streaming, stall, reset flush and random traffic.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] exp_q [$];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    pipe_adder #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ovf, cout, sum} from wide arithmetic and sign comparison.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] r;
        logic        v;
        yy = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {16'd0, (sb ? 1'b1 : ci)};
        v  = (x[15] == yy[15]) && (r[15] != x[15]);
        return {v, r[16], r[15:0]};
    endfunction

    // Scoreboard: transfers are judged mid-cycle, before the next edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    chk("sb_result", {14'd0, ovf, cout, sum},
                        {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_one(input vec_t v);
        int lat;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("sum", {16'd0, sum}, {16'd0, v.s});
        chk("cout", {31'd0, cout}, {31'd0, v.co});
        chk("ovf", {31'd0, ovf}, {31'd0, v.ov});
    endtask

    vec_t vecs [9];

    initial begin
        int first_out;
        int last_out;
        int nout;
        logic [15:0] held;

        vecs = '{
            '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
            '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
            '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0},
            '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0},
            '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
            '{16'h1234, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0}
        };

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed single operations.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) run_one(vecs[i]);
        repeat (3) tick();

        // Eight back-to-back operations.
        first_out = -1;
        last_out  = -1;
        nout      = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid) begin
                if (first_out < 0) first_out = i;
                last_out = i;
                nout++;
            end
            in_valid = (i < 8);
            a        = 16'(i * 16'h1111);
            b        = 16'(16'h0F0F + i);
            cin      = i[0];
            sub      = i[1];
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_first", 32'(first_out), 32'd4);
        chk("b2b_count", 32'(nout), 32'd8);
        chk("b2b_span", 32'(last_out - first_out), 32'd7);

        // Fill the pipe with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a        = 16'h1234 + 16'(i);
            b        = 16'h1111;
            cin      = 1'b0;
            sub      = 1'b0;
            tick();
        end
        a = 16'h4000;
        b = 16'h0001;
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_first", {16'd0, sum}, 32'h2345);
        held = sum;
        for (int j = 0; j < 3; j++) begin
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_hold", {16'd0, sum}, {16'd0, held});
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        chk("stall_drain", 32'(exp_q.size()), 32'd0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'hA000 + 16'(i);
            b        = 16'h0101;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_sum", {16'd0, sum}, 32'd0);
        nout = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) nout++;
            tick();
        end
        chk("flush_none", 32'(nout), 32'd0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
        chk("rand_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits; SHALL be a multiple of CHUNK and at least CHUNK.
REQ-002 Parameter CHUNK, default 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK SHALL be derived, not set by the user.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  operand set presented this cycle.
REQ-006 in_ready  out  1  block accepts an operand set this cycle.
REQ-007 a, b  in  WIDTH  operands, unsigned or two's complement.
REQ-008 cin  in  1  carry-in for add mode; ignored in subtract mode.
REQ-009 sub  in  1  0 = a+b+cin, 1 = a-b (a + ~b + 1).
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes the result this cycle.
REQ-012 sum  out  WIDTH  result modulo 2^WIDTH.
REQ-013 cout  out  1  carry out of the MSB; in subtract mode 1 means no borrow (a >= b unsigned).
REQ-014 ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 SHALL split the operation into STAGES ripple stages of CHUNK bits each; stage k adds bits [k*CHUNK +: CHUNK] using the carry registered from stage k-1.
REQ-016 Operand bits not yet consumed and partial sum bits already produced SHALL be carried forward in registers alongside each stage's valid bit (skewed pipeline).
REQ-017 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, with no stall.
REQ-019 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-020 Stall: when out_valid && !out_ready, every stage SHALL hold, in_ready SHALL be 0, and sum/cout/ovf SHALL stay stable.
REQ-021 in_ready = !(out_valid && !out_ready); an input and an output transfer in the same cycle SHALL both complete.
REQ-022 Bubbles (in_valid=0) SHALL propagate as invalid stages and never produce out_valid.
REQ-023 sub SHALL be captured at input transfer; ~b and forced carry-in 1 SHALL be applied at stage 0.
REQ-024 ovf SHALL use the carry into bit WIDTH-1, which sits inside the last stage.
REQ-025 Inputs SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-026 rst SHALL clear all stage valid bits; out_valid=0, sum=0, cout=0, ovf=0 on the cycle after rst is sampled high.
REQ-027 rst during operation SHALL discard all in-flight operations; no result of an operation accepted before rst SHALL appear afterwards.
REQ-028 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-029 Shared package adder_pkg SHALL hold the default WIDTH/CHUNK constants and the STAGES derivation.
REQ-030 Sub-module adder_chunk (combinational CHUNK-bit ripple adder: a, b, cin -> s, cout, carry into MSB) SHALL be instantiated once per stage.

Verification (WIDTH=16, CHUNK=4)
REQ-031 Stimulus a=0x00FF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0100, cout=0, ovf=0; checks carry crossing stage boundaries.
REQ-032 Stimulus a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0; stimulus a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-033 Stimulus: 8 back-to-back operations with out_ready=1 -> 8 consecutive out_valid cycles, in order, first result 4 cycles after first input.
REQ-034 Stimulus: out_ready=0 for 3 cycles while the pipe is full -> in_ready=0, outputs held stable, no loss or duplication after release.
REQ-035 Stimulus: rst pulsed with 3 operations in flight -> out_valid=0 next cycle; none of the 3 results ever appears.
REQ-036 Stimulus: 10k random a, b, cin, sub with random out_ready -> every result matches the reference model for sum, cout and ovf.
